// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and fills IF/ID.
// Optional perf counters (fetch/bubble/stall) are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int N  = 64,
    parameter int I  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          pcsrc,
    input  logic [N-1:0]  branch_target,
    output logic [AW-1:0] imem_addr,
    input  logic [I-1:0]  imem_q,
    output logic [N-1:0]  pc,
    output logic [N-1:0]  if_id_pc,
    output logic [I-1:0]  if_id_instr,
    output logic          if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   stall_cnt
`endif
);

    typedef enum logic [2:0] {
        ACT_RUN,
        ACT_HOLD,
        ACT_BUBBLE_HOLD,
        ACT_BUBBLE_STEP,
        ACT_REDIRECT
    } act_t;

    act_t         act;
    logic [N-1:0] pc_plus4;

    assign imem_addr = pc[AW+1:2];
    assign pc_plus4  = pc + N'(4);

    always_comb begin
        act = ACT_RUN;
        if (pcsrc)
            act = ACT_REDIRECT;
        else if (stall && flush)
            act = ACT_BUBBLE_HOLD;
        else if (stall)
            act = ACT_HOLD;
        else if (flush)
            act = ACT_BUBBLE_STEP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else begin
            case (act)
                ACT_REDIRECT: begin
                    pc          <= {branch_target[N-1:2], 2'b00};
                    if_id_pc    <= '0;
                    if_id_instr <= '0;
                    if_id_valid <= 1'b0;
                end
                ACT_BUBBLE_HOLD: begin
                    if_id_pc    <= '0;
                    if_id_instr <= '0;
                    if_id_valid <= 1'b0;
                end
                ACT_HOLD: begin
                end
                ACT_BUBBLE_STEP: begin
                    pc          <= pc_plus4;
                    if_id_pc    <= '0;
                    if_id_instr <= '0;
                    if_id_valid <= 1'b0;
                end
                default: begin
                    pc          <= pc_plus4;
                    if_id_pc    <= pc;
                    if_id_instr <= imem_q;
                    if_id_valid <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            case (act)
                ACT_RUN:  fetch_cnt  <= fetch_cnt + 32'd1;
                ACT_HOLD: stall_cnt  <= stall_cnt + 32'd1;
                default:  bubble_cnt <= bubble_cnt + 32'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; ROM model returns 32'hA000_0000 | word address.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [63:0] branch_target;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic [63:0] pc;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    assign imem_q = 32'hA000_0000 | {26'd0, imem_addr};

    fetch_stage #(.N(64), .I(32), .AW(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_q        (imem_q),
        .pc            (pc),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .bubble_cnt    (bubble_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs, then sample 1ns after the following rising edge.
    task automatic cycle(input logic r, input logic s, input logic f, input logic p,
                         input logic [63:0] t);
        reset = r; stall = s; flush = f; pcsrc = p; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [63:0] epc,
                              input logic [31:0] einstr, input logic evalid);
        check({tag, ".if_id_pc"}, if_id_pc, epc);
        check({tag, ".if_id_instr"}, {32'd0, if_id_instr}, {32'd0, einstr});
        check({tag, ".if_id_valid"}, {63'd0, if_id_valid}, {63'd0, evalid});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 1'b0; branch_target = '0;

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("reset.pc", pc, 64'h0);
        check("reset.imem_addr", {58'd0, imem_addr}, 64'd0);
        check_ifid("reset", 64'h0, 32'h0, 1'b0);

        // Sequential fetch
        cycle(0, 0, 0, 0, 0);
        check("run1.pc", pc, 64'h4);
        check_ifid("run1", 64'h0, 32'hA000_0000, 1'b1);
        cycle(0, 0, 0, 0, 0);
        check("run2.pc", pc, 64'h8);
        check_ifid("run2", 64'h4, 32'hA000_0001, 1'b1);
        cycle(0, 0, 0, 0, 0);
        check("run3.pc", pc, 64'hC);
        check_ifid("run3", 64'h8, 32'hA000_0002, 1'b1);
        cycle(0, 0, 0, 0, 0);
        check("run4.pc", pc, 64'h10);
        check_ifid("run4", 64'hC, 32'hA000_0003, 1'b1);

        // Stall for three edges
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 0);
            check("stall.pc", pc, 64'h10);
            check_ifid("stall", 64'hC, 32'hA000_0003, 1'b1);
        end
        cycle(0, 0, 0, 0, 0);
        check("unstall.pc", pc, 64'h14);
        check_ifid("unstall", 64'h10, 32'hA000_0004, 1'b1);

        // Redirect with stall: redirect wins, low bits of target cleared
        cycle(0, 1, 0, 1, 64'h2B);
        check("redir.pc", pc, 64'h28);
        check_ifid("redir", 64'h0, 32'h0, 1'b0);
        cycle(0, 0, 0, 0, 0);
        check("redir_next.pc", pc, 64'h2C);
        check_ifid("redir_next", 64'h28, 32'hA000_000A, 1'b1);

        // Flush alone, then flush with stall
        cycle(0, 0, 0, 1, 64'h20);
        check("to20.pc", pc, 64'h20);
        cycle(0, 0, 1, 0, 0);
        check("flush.pc", pc, 64'h24);
        check_ifid("flush", 64'h0, 32'h0, 1'b0);
        cycle(0, 0, 0, 0, 0);
        check("pre_fs.pc", pc, 64'h28);
        check_ifid("pre_fs", 64'h24, 32'hA000_0009, 1'b1);
        cycle(0, 1, 1, 0, 0);
        check("flush_stall.pc", pc, 64'h28);
        check_ifid("flush_stall", 64'h0, 32'h0, 1'b0);

        // ROM address wrap past word 63
        cycle(0, 0, 0, 1, 64'hFC);
        check("wrap.pc", pc, 64'hFC);
        check("wrap.imem_addr", {58'd0, imem_addr}, 64'd63);
        cycle(0, 0, 0, 0, 0);
        check("wrap1.pc", pc, 64'h100);
        check("wrap1.imem_addr", {58'd0, imem_addr}, 64'd0);
        check_ifid("wrap1", 64'hFC, 32'hA000_003F, 1'b1);
        cycle(0, 0, 0, 0, 0);
        check("wrap2.pc", pc, 64'h104);
        check_ifid("wrap2", 64'h100, 32'hA000_0000, 1'b1);

        // PC arithmetic wraps modulo 2^64
        cycle(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("top.pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 0, 0, 0, 0);
        check("pcwrap.pc", pc, 64'h0);
        check_ifid("pcwrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'hA000_003F, 1'b1);

        // Reset overrides stall, flush and pcsrc
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 64'h80);
        check("mid_reset.pc", pc, 64'h0);
        check_ifid("mid_reset", 64'h0, 32'h0, 1'b0);

        // 5 normal, 2 flush, 3 stall edges
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        check("cnt_run.pc", pc, 64'h14);
        check_ifid("cnt_run", 64'h10, 32'hA000_0004, 1'b1);
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        check("cnt_end.pc", pc, 64'h1C);
        check_ifid("cnt_end", 64'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", {32'd0, fetch_cnt}, 64'd5);
        check("bubble_cnt", {32'd0, bubble_cnt}, 64'd2);
        check("stall_cnt", {32'd0, stall_cnt}, 64'd3);
        cycle(1, 0, 0, 0, 0);
        check("cnt_reset.fetch", {32'd0, fetch_cnt}, 64'd0);
        check("cnt_reset.bubble", {32'd0, bubble_cnt}, 64'd0);
        check("cnt_reset.stall", {32'd0, stall_cnt}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
